cmu_diag_add_seq: RTL and testbench
===================================

// Module: cmu_diag_add_seq
// PURPOSE
//  Parametrised successor of the single-element covariance-diagonal adder in the Kalman CMU.
//  Computes r[i] = theta[i] +/- q[i] for N_CH IEEE-754 doubles (P-prior diagonal = Theta + Q).
//  All lanes share one time-multiplexed fp_adder; a valid/ready handshake sits on both sides.
//  Sits between the Theta/Q generators and the covariance-update datapath.
// PARAMETERS
//  DBL_WIDTH  64  operand/result width in bits; bit DBL_WIDTH-1 is the sign.
//  N_CH       4   lanes per job; range 1..16.
// PORTS
//  clk        in   1               clock; all logic on the rising edge.
//  rst        in   1               synchronous, active-high reset.
//  in_valid   in   1               job offered.
//  in_ready   out  1               block can accept a job; high only in S_IDLE.
//  sub        in   1               0: r = theta + q; 1: r = theta - q. Sampled at accept.
//  theta      in   N_CH*DBL_WIDTH  lane i at [i*DBL_WIDTH +: DBL_WIDTH].
//  q          in   N_CH*DBL_WIDTH  same packing as theta.
//  out_valid  out  1               result vector valid; held until accepted.
//  out_ready  in   1               consumer accepts the result.
//  result     out  N_CH*DBL_WIDTH  same packing; stable while out_valid = 1.
//  busy       out  1               high in every state except S_IDLE.
// BEHAVIOUR
//  - Reset (rst = 1 at an edge): state S_IDLE, lane index 0, add_go 0, out_valid 0, result 0,
//    busy 0. Any in-flight job is dropped. A late fp_adder finish after reset is ignored.
//  - Accept: when in_valid && in_ready, theta, q and sub are registered. The next state is S_ISSUE.
//    Inputs may change after the accept cycle.
//  - S_ISSUE: drive add_a = theta_r[idx].
//    - Drive add_b = q_r[idx], with the sign bit XOR sub_r (subtract = sign flip).
//    - When the fp_adder ready is high, pulse add_go for exactly 1 cycle and go to S_WAIT.
//    - Otherwise stay in S_ISSUE.
//  - S_WAIT: on add_finish, write add_r into result[idx].
//    - If idx == N_CH-1, go to S_DONE.
//    - Otherwise idx++ and go to S_ISSUE.
//    - add_go is never high in S_WAIT.
//  - S_DONE: out_valid = 1 (registered).
//    - On out_valid && out_ready: clear out_valid, idx := 0, go to S_IDLE.
//    - in_ready rises the following cycle; there is no same-cycle turnaround.
//  - Latency: accept to out_valid = N_CH*(L+2)+1 cycles, where L is the fp_adder go->finish latency
//    and the adder is ready on every issue. Stalls on the adder's ready add cycle-for-cycle.
//  - Back-pressure: out_ready low holds S_DONE, result and out_valid indefinitely.
//  - Lanes are processed in ascending order.
//    - result lanes not yet written keep their previous job's values.
//    - result is only defined while out_valid = 1.
//  - in_valid while busy: ignored (in_ready = 0); no operand capture.
//  - Result bits are passed through unchanged from the fp_adder (no rounding, NaN or Inf handling here).
//  - N_CH = 1: idx width is 1 bit, and the S_WAIT -> S_DONE path is taken directly.
// STRUCTURE
//  - Package cmu_pkg:
//    - typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} seq_st_e
//    - localparam function clog2_min1(n), giving the idx width (minimum 1)
//    - DBL_SIGN_BIT constant
//  - One instance of the existing fp_adder, u_add0:
//    - ports: clk, rst_n = ~rst, valid = add_go, ready, finish, a, b, result.
//  - Operand store: theta_r/q_r register arrays; no separate sub-module is needed.
// TESTING
//  - Constants: 1.0 = 3FF0000000000000, 2.0 = 4000000000000000, 3.0 = 4008000000000000, 0.5 = 3FE0000000000000.
//  - T1 Basic add, N_CH=4, sub=0, theta all 1.0, q all 2.0:
//    - every lane is 3.0;
//    - out_valid appears exactly N_CH*(L+2)+1 cycles after accept.
//  - T2 Subtract, sub=1, theta[i] = 3.0, q[i] = 2.0:
//    - lanes are 1.0;
//    - q = 0.5 with theta = 1.0 gives 0.5 (3FE0...).
//  - T3 Lane order/packing, theta = {1.0, 2.0, 3.0, 0.5} (lane0 first), q all 0:
//    - result equals theta lane-for-lane;
//    - add_go pulses exactly 4 times, each 1 cycle wide.
//  - T4 Back-pressure: hold out_ready = 0 for 10 cycles after out_valid.
//    - result and out_valid stay stable;
//    - in_ready stays 0;
//    - a second in_valid is not accepted.
//  - T5 Reset mid-job: assert rst while in S_WAIT of lane 2.
//    - Next cycle: busy = 0, out_valid = 0, in_ready = 1.
//    - A new job (1.0 + 1.0) yields 2.0 on all lanes.
//  - T6 Adder stall: the model holds ready low for 5 cycles before each issue.
//    - Latency grows by exactly 5*N_CH cycles.
//    - Results are unchanged. Repeat the T1 stimulus with N_CH=1.

Source files
------------

// File: rtl/cmu_pkg.sv
// Shared types and helpers for the CMU covariance-diagonal adder sequencer.
package cmu_pkg;

  localparam int unsigned DBL_W        = 64;
  localparam int unsigned DBL_SIGN_BIT = DBL_W - 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} seq_st_e;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Double add, round-to-nearest-even, subnormals flushed to zero, no NaN/Inf inputs.
  function automatic logic [DBL_W-1:0] fp64_add(input logic [DBL_W-1:0] a,
                                                input logic [DBL_W-1:0] b);
    logic [DBL_W-1:0]  x, y;
    logic [55:0]       mx, my, ms;
    logic [56:0]       s;
    logic [10:0]       d;
    logic [53:0]       m;
    logic              rnd;
    logic signed [12:0] e;
    if (a[62:52] == 11'd0) return b;
    if (b[62:52] == 11'd0) return a;
    if (a[62:0] >= b[62:0]) begin
      x = a; y = b;
    end else begin
      x = b; y = a;
    end
    mx = {1'b1, x[51:0], 3'b000};
    my = {1'b1, y[51:0], 3'b000};
    d  = x[62:52] - y[62:52];
    if (d >= 11'd56) begin
      ms = 56'd1;
    end else begin
      ms    = my >> d;
      ms[0] = ms[0] | (|(my & ((56'd1 << d) - 56'd1)));
    end
    s = (x[DBL_SIGN_BIT] == y[DBL_SIGN_BIT]) ? ({1'b0, mx} + {1'b0, ms})
                                             : ({1'b0, mx} - {1'b0, ms});
    e = $signed({2'b00, x[62:52]});
    if (s == 57'd0) return '0;
    if (s[56]) begin
      s = {1'b0, s[56:1]} | {56'd0, s[0]};
      e = e + 13'sd1;
    end else begin
      for (int i = 0; i < 55; i++) begin
        if (!s[55]) begin
          s = s << 1;
          e = e - 13'sd1;
        end
      end
    end
    if (e <= 13'sd0) return {x[DBL_SIGN_BIT], 63'd0};
    if (e >= 13'sd2047) return {x[DBL_SIGN_BIT], 11'h7ff, 52'd0};
    rnd = s[2] & (s[1] | s[0] | s[3]);
    m   = {1'b0, s[55:3]} + {53'd0, rnd};
    // Hidden bit and rounding carry both ripple into the exponent field.
    return {x[DBL_SIGN_BIT], {e[10:0] - 11'd1, 52'd0} + {9'd0, m}};
  endfunction

endpackage

// File: rtl/fp_adder.sv
// Multi-cycle double-precision adder with go/finish handshake and configurable
// post-reset / post-finish busy window.
module fp_adder
  import cmu_pkg::*;
#(
  parameter int unsigned LATENCY = 3,
  parameter int unsigned STALL   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid,
  output logic             ready,
  output logic             finish,
  input  logic [DBL_W-1:0] a,
  input  logic [DBL_W-1:0] b,
  output logic [DBL_W-1:0] result
);

  localparam int unsigned CNT_W = clog2_min1(STALL + 1);

  logic               rst_sync_q;
  logic               busy_q;
  logic [CNT_W-1:0]   stall_q;
  logic [LATENCY-1:0] pipe_q;
  logic [DBL_W-1:0]   res_q;
  logic               fire;

  assign ready  = rst_sync_q && !busy_q && (stall_q == '0);
  assign fire   = valid && ready;
  assign finish = pipe_q[LATENCY-1];
  assign result = res_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 1'b0;
    else        rst_sync_q <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q  <= 1'b0;
      stall_q <= CNT_W'(STALL);
      pipe_q  <= '0;
      res_q   <= '0;
    end else if (!rst_sync_q) begin
      busy_q  <= 1'b0;
      stall_q <= CNT_W'(STALL);
      pipe_q  <= '0;
    end else begin
      pipe_q <= LATENCY'({pipe_q, fire});
      if (fire) begin
        busy_q <= 1'b1;
        res_q  <= fp64_add(a, b);
      end
      if (finish) begin
        busy_q  <= 1'b0;
        stall_q <= CNT_W'(STALL);
      end else if (stall_q != '0) begin
        stall_q <= stall_q - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/cmu_diag_add_seq.sv
// P-prior diagonal: r[i] = theta[i] +/- q[i] for N_CH doubles through one shared fp_adder.
module cmu_diag_add_seq
  import cmu_pkg::*;
#(
  parameter int unsigned DBL_WIDTH = 64,
  parameter int unsigned N_CH      = 4,
  parameter int unsigned ADD_LAT   = 3,
  parameter int unsigned ADD_STALL = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      sub,
  input  logic [N_CH*DBL_WIDTH-1:0] theta,
  input  logic [N_CH*DBL_WIDTH-1:0] q,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [N_CH*DBL_WIDTH-1:0] result,
  output logic                      busy
);

  localparam int unsigned IDX_W  = clog2_min1(N_CH);
  localparam int unsigned N_SLOT = 1 << IDX_W;

  seq_st_e                          state_q;
  logic [IDX_W-1:0]                 idx_q;
  logic                             add_go_q;
  logic                             out_valid_q;
  logic                             in_ready_q;
  logic                             busy_q;
  logic                             sub_q;
  logic [N_SLOT-1:0][DBL_WIDTH-1:0] theta_q;
  logic [N_SLOT-1:0][DBL_WIDTH-1:0] q_q;
  logic [N_SLOT-1:0][DBL_WIDTH-1:0] res_q;

  logic                 add_ready;
  logic                 add_finish;
  logic [DBL_WIDTH-1:0] add_a;
  logic [DBL_WIDTH-1:0] add_b;
  logic [DBL_WIDTH-1:0] add_res;

  // Subtraction is a sign flip on the q operand.
  always_comb begin
    add_a                = theta_q[idx_q];
    add_b                = q_q[idx_q];
    add_b[DBL_WIDTH-1]   = q_q[idx_q][DBL_WIDTH-1] ^ sub_q;
  end

  fp_adder #(
    .LATENCY (ADD_LAT),
    .STALL   (ADD_STALL)
  ) u_add0 (
    .clk    (clk),
    .rst_n  (~rst),
    .valid  (add_go_q),
    .ready  (add_ready),
    .finish (add_finish),
    .a      (add_a),
    .b      (add_b),
    .result (add_res)
  );

  // Issue holds one extra cycle while go is high so go never overlaps S_WAIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      add_go_q    <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      res_q       <= '0;
    end else begin
      add_go_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (in_valid && in_ready_q) begin
            theta_q[N_CH-1:0] <= theta;
            q_q[N_CH-1:0]     <= q;
            sub_q             <= sub;
            in_ready_q        <= 1'b0;
            busy_q            <= 1'b1;
            state_q           <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (add_go_q)       state_q  <= S_WAIT;
          else if (add_ready) add_go_q <= 1'b1;
        end
        S_WAIT: begin
          if (add_finish) begin
            res_q[idx_q] <= add_res;
            if (idx_q == IDX_W'(N_CH - 1)) begin
              out_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end else begin
              idx_q   <= idx_q + IDX_W'(1);
              state_q <= S_ISSUE;
            end
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            idx_q       <= '0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign result    = res_q[N_CH-1:0];

endmodule

// File: tb/tb_cmu_diag_add_seq.sv
// Directed bench: 4-lane sequencer (no adder stall) and 1-lane sequencer (5-cycle adder stall).
module tb_cmu_diag_add_seq;
  import cmu_pkg::*;

  localparam logic [63:0] ONE   = 64'h3FF0000000000000;
  localparam logic [63:0] TWO   = 64'h4000000000000000;
  localparam logic [63:0] THREE = 64'h4008000000000000;
  localparam logic [63:0] HALF  = 64'h3FE0000000000000;
  localparam int          L     = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         a_rst, a_in_valid, a_in_ready, a_sub, a_out_valid, a_out_ready, a_busy;
  logic [255:0] a_theta, a_q, a_result;
  logic         b_rst, b_in_valid, b_in_ready, b_sub, b_out_valid, b_out_ready, b_busy;
  logic [63:0]  b_theta, b_q, b_result;

  cmu_diag_add_seq #(.DBL_WIDTH(64), .N_CH(4), .ADD_LAT(L), .ADD_STALL(0)) u_a (
    .clk(clk), .rst(a_rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .sub(a_sub),
    .theta(a_theta), .q(a_q), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .result(a_result), .busy(a_busy));

  cmu_diag_add_seq #(.DBL_WIDTH(64), .N_CH(1), .ADD_LAT(L), .ADD_STALL(5)) u_b (
    .clk(clk), .rst(b_rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .sub(b_sub),
    .theta(b_theta), .q(b_q), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .result(b_result), .busy(b_busy));

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // go pulse monitor on the 4-lane instance
  int   go_cnt = 0, go_wide = 0, go_in_wait = 0;
  logic go_prev = 1'b0;
  always @(negedge clk) begin
    if (u_a.add_go_q) go_cnt++;
    if (u_a.add_go_q && go_prev) go_wide++;
    if (u_a.add_go_q && u_a.state_q == S_WAIT) go_in_wait++;
    go_prev = u_a.add_go_q;
  end

  task automatic a_job(input logic [255:0] th, input logic [255:0] qv, input logic s,
                       output int lat);
    @(negedge clk);
    a_in_valid = 1'b1; a_theta = th; a_q = qv; a_sub = s;
    @(posedge clk);
    @(negedge clk);
    a_in_valid = 1'b0;
    a_theta = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    a_q     = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    a_sub   = ~s;
    lat = 1;
    while (!a_out_valid && lat < 300) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic a_lanes(input string tag, input logic [255:0] exp);
    for (int i = 0; i < 4; i++)
      check_eq($sformatf("%s_lane%0d", tag, i), a_result[i*64 +: 64], exp[i*64 +: 64]);
  endtask

  task automatic a_pop(input string tag);
    @(negedge clk);
    a_out_ready = 1'b1;
    check_eq({tag, "_in_ready_done"}, a_in_ready, 1'b0);
    @(posedge clk);
    @(negedge clk);
    a_out_ready = 1'b0;
    check_eq({tag, "_out_valid_clr"}, a_out_valid, 1'b0);
    check_eq({tag, "_in_ready_idle"}, a_in_ready, 1'b1);
    check_eq({tag, "_busy_idle"}, a_busy, 1'b0);
  endtask

  int           lat;
  int           waited;
  logic [255:0] exp;

  initial begin
    a_rst = 1'b1; a_in_valid = 1'b0; a_sub = 1'b0; a_theta = '0; a_q = '0; a_out_ready = 1'b0;
    b_rst = 1'b1; b_in_valid = 1'b0; b_sub = 1'b0; b_theta = '0; b_q = '0; b_out_ready = 1'b0;
    repeat (3) @(negedge clk);

    check_eq("rst_a_busy", a_busy, 1'b0);
    check_eq("rst_a_out_valid", a_out_valid, 1'b0);
    check_eq("rst_a_in_ready", a_in_ready, 1'b1);
    check_eq("rst_a_result", a_result, 256'd0);
    check_eq("rst_a_idx", u_a.idx_q, 2'd0);
    check_eq("rst_b_busy", b_busy, 1'b0);
    check_eq("rst_b_result", b_result, 64'd0);

    // T6: single lane, adder busy for 5 cycles ahead of the issue
    a_rst = 1'b0;
    b_rst = 1'b0; b_in_valid = 1'b1; b_theta = ONE; b_q = TWO; b_sub = 1'b0;
    @(posedge clk);
    @(negedge clk);
    b_in_valid = 1'b0; b_theta = TWO; b_q = TWO; b_sub = 1'b1;
    lat = 1;
    while (!b_out_valid && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    check_eq("t6_latency", lat, 1 * (L + 2) + 1 + 5 * 1);
    check_eq("t6_result", b_result, THREE);
    b_out_ready = 1'b1;
    @(negedge clk);
    b_out_ready = 1'b0;
    check_eq("t6_out_valid_clr", b_out_valid, 1'b0);
    check_eq("t6_in_ready", b_in_ready, 1'b1);

    // T1: basic add
    a_job({4{ONE}}, {4{TWO}}, 1'b0, lat);
    check_eq("t1_latency", lat, 4 * (L + 2) + 1);
    a_lanes("t1", {4{THREE}});
    a_pop("t1");

    // T2: subtract; lanes 0-1 are 3-2, lanes 2-3 are 1-0.5
    a_job({ONE, ONE, THREE, THREE}, {HALF, HALF, TWO, TWO}, 1'b1, lat);
    check_eq("t2_latency", lat, 4 * (L + 2) + 1);
    a_lanes("t2", {HALF, HALF, ONE, ONE});
    a_pop("t2");

    // T3: lane order and go pulse shape
    go_cnt = 0; go_wide = 0;
    a_job({HALF, THREE, TWO, ONE}, 256'd0, 1'b0, lat);
    a_lanes("t3", {HALF, THREE, TWO, ONE});
    check_eq("t3_go_count", go_cnt, 4);
    check_eq("t3_go_wide", go_wide, 0);
    a_pop("t3");

    // T4: back-pressure with a competing job offered
    a_job({4{TWO}}, {4{ONE}}, 1'b0, lat);
    exp = {4{THREE}};
    for (int c = 0; c < 10; c++) begin
      a_in_valid = 1'b1; a_theta = {4{HALF}}; a_q = {4{HALF}}; a_sub = 1'b0;
      check_eq($sformatf("t4_out_valid_c%0d", c), a_out_valid, 1'b1);
      check_eq($sformatf("t4_in_ready_c%0d", c), a_in_ready, 1'b0);
      check_eq($sformatf("t4_result_c%0d", c), a_result, exp);
      @(negedge clk);
    end
    a_in_valid = 1'b0;
    check_eq("t4_result_end", a_result, exp);
    a_pop("t4");
    repeat (2) @(negedge clk);
    check_eq("t4_no_second_accept", a_busy, 1'b0);

    // T5: reset during lane 2 wait
    @(negedge clk);
    a_in_valid = 1'b1; a_theta = {4{THREE}}; a_q = {4{ONE}}; a_sub = 1'b0;
    @(posedge clk);
    @(negedge clk);
    a_in_valid = 1'b0;
    waited = 0;
    while (!(u_a.state_q == S_WAIT && u_a.idx_q == 2'd2) && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check_eq("t5_reached_lane2_wait", waited < 200, 1'b1);
    a_rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("t5_busy", a_busy, 1'b0);
    check_eq("t5_out_valid", a_out_valid, 1'b0);
    check_eq("t5_in_ready", a_in_ready, 1'b1);
    a_rst = 1'b0;
    a_job({4{ONE}}, {4{ONE}}, 1'b0, lat);
    check_eq("t5_out_valid_new", a_out_valid, 1'b1);
    a_lanes("t5", {4{TWO}});
    a_pop("t5");

    check_eq("go_never_in_wait", go_in_wait, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
